fcb_n_deep_parametrised: RTL and testbench
==========================================

Name: fcb_n_deep_parametrised

Overview:
Parametrised flow-controlled buffer with configurable data width and depth. It uses the same valid/ready handshake as the codebase's single-register flow-control blocks. A mode parameter selects one of two behaviours:
- fully registered up_rdy, with no combinational path from down_rdy, for deep pipelines;
- up_rdy also asserted on a simultaneous pop when full, for full-occupancy throughput.
It drops between pipeline stages to cut timing paths or absorb bursts, and exposes occupancy for debug and backpressure monitoring.

Parameters:
w, 8, data width in bits; must be >= 1.
depth, 2, number of storage entries; must be >= 2 and need not be a power of two.
comb_rdy, 0, 0 = up_rdy depends only on registered state; 1 = up_rdy also asserted when full and down_rdy is high (combinational down_rdy -> up_rdy path).

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  reset, synchronous, active-high
up_vld  input  1  upstream data valid
up_rdy  output  1  buffer can accept upstream data this cycle
up_data  input  w  upstream data
down_vld  output  1  buffer holds data for downstream
down_rdy  input  1  downstream accepts data this cycle
down_data  output  w  head-of-buffer data
count  output  $clog2(depth+1)  current number of stored entries, 0..depth

Behaviour:
- Reset is synchronous and active-high. At the first rising edge with rst=1:
  - count=0, down_vld=0, down_data='0, up_rdy=1;
  - read and write pointers = 0;
  - all storage entries = '0.
  - rst overrides any handshake in the same cycle: nothing is pushed or popped.
- Reset mid-operation discards all contents; the next cycle behaves exactly as after power-up reset.
- Push = up_vld & up_rdy. Pop = down_vld & down_rdy. Both take effect at the clock edge.
- up_rdy:
  - comb_rdy=0: up_rdy = (count != depth).
  - comb_rdy=1: up_rdy = (count != depth) | down_rdy.
- down_vld = (count != 0). down_data = entry at the read pointer. Both come straight from registers, with no combinational path from up_* to down_*.
- Latency: data pushed at edge N is visible on down_data/down_vld after edge N. There is no same-cycle bypass when empty.
- Pointers:
  - width $clog2(depth); each wraps from depth-1 to 0.
  - write pointer advances on push; read pointer advances on pop.
- count:
  - +1 on push only; -1 on pop only; unchanged on both or neither.
- Empty with simultaneous push and pop: impossible, since down_vld=0 means no pop. The push lands and count becomes 1.
- Full:
  - comb_rdy=0: a push is refused even if down_rdy=1. Pop only, count becomes depth-1.
  - comb_rdy=1 with down_rdy=1: push and pop happen together, count stays depth, the written entry is the slot freed by the pop, and pointers advance together.
- Throughput: sustained 1 transfer per cycle with down_rdy held high in both modes, because depth >= 2.
- Data integrity:
  - strict FIFO order; no duplication or loss.
  - down_data and down_vld hold stable while down_vld=1 and down_rdy=0.
- up_data is ignored when push=0. Storage is written only on push.

Decomposition:
- No shared package types are needed. Pointer and count widths are derived locally with $clog2.
- Natural sub-module: fcb_ptr_wrap, a parametrised modulo-depth pointer incrementer with synchronous reset, instantiated twice (read and write).
- Storage stays an inline array in the top module.

Test Plan:
1. Reset, then stream 0x01..0x10 with down_rdy=1, depth=2, comb_rdy=0 -> down_data 0x01..0x10 in order, one per cycle after 1-cycle latency; count stays <= 1; up_rdy never drops.
2. depth=4, push 0xA0..0xA3 with down_rdy=0 -> count=4, up_rdy=0. Raise down_rdy with up_vld=1, up_data=0xA4 -> comb_rdy=0: 0xA4 refused that cycle, count=3; comb_rdy=1: 0xA4 accepted, count stays 4, output order A0,A1,A2,A3,A4.
3. depth=3 (non-power-of-two), 10 push/pop cycles with random stalls and data 0x00..0x09 -> pointers wrap 2->0 correctly; all 10 values out in order; count matches a reference model each cycle.
4. Stall hold: down_vld=1, down_data=0x5A, down_rdy=0 for 5 cycles -> down_data and down_vld unchanged throughout.
5. Reset mid-operation with count=2 and up_vld=1 -> next cycle count=0, down_vld=0, down_data=0, up_rdy=1; the in-flight push is not stored.
6. Random up_vld/down_rdy for 10k cycles, w=16, depth=5, both comb_rdy values -> scoreboard shows no loss, duplication or reordering. Assertion: when comb_rdy=0, up_rdy is a function of registered state only.

Source files
------------

// File: rtl/fcb_n_deep_parametrised_pkg.sv
// Shared constants and width helpers for the n-deep flow-controlled buffer.
package fcb_n_deep_parametrised_pkg;

    localparam int unsigned FCB_MIN_DEPTH = 2;
    localparam int unsigned FCB_MIN_W     = 1;

    // Pointer width; clamped so a degenerate depth still yields a legal vector.
    function automatic int unsigned fcb_ptr_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned fcb_cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fcb_n_deep_parametrised_ptr_wrap.sv
// Modulo-depth pointer: advances on i_inc and wraps from depth-1 back to 0.
module fcb_ptr_wrap
    import fcb_n_deep_parametrised_pkg::*;
#(
    parameter  int unsigned depth = 2,
    localparam int unsigned PW    = fcb_ptr_w(depth)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inc,
    output logic [PW-1:0] o_ptr
);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_nxt;

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (i_inc) begin
            w_ptr_nxt = (r_ptr == PW'(depth - 1)) ? '0 : r_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fcb_n_deep_parametrised.sv
// Parametrised valid/ready buffer of `depth` entries with occupancy output.
// comb_rdy selects a registered up_rdy or one that also opens on a pop when full.
module fcb_n_deep_parametrised
    import fcb_n_deep_parametrised_pkg::*;
#(
    parameter  int unsigned w        = 8,
    parameter  int unsigned depth    = 2,
    parameter  int unsigned comb_rdy = 0,
    localparam int unsigned PW       = fcb_ptr_w(depth),
    localparam int unsigned CW       = fcb_cnt_w(depth)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_vld,
    output logic          up_rdy,
    input  logic [w-1:0]  up_data,
    output logic          down_vld,
    input  logic          down_rdy,
    output logic [w-1:0]  down_data,
    output logic [CW-1:0] count
);

    if (depth < FCB_MIN_DEPTH) begin : g_bad_depth
        $error("fcb_n_deep_parametrised: depth must be >= 2");
    end
    if (w < FCB_MIN_W) begin : g_bad_w
        $error("fcb_n_deep_parametrised: w must be >= 1");
    end

    logic [w-1:0]  r_mem [depth];
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_not_full;
    logic          r_down_vld;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_wr_ptr;
    logic [PW-1:0] w_rd_ptr;

    // Full-occupancy mode lets a downstream pop free the slot for this cycle's push.
    if (comb_rdy != 0) begin : g_comb_rdy
        assign up_rdy = r_not_full | down_rdy;
    end else begin : g_reg_rdy
        assign up_rdy = r_not_full;
    end

    assign w_push = up_vld & up_rdy;
    assign w_pop  = r_down_vld & down_rdy;

    fcb_ptr_wrap #(.depth(depth)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_push),
        .o_ptr (w_wr_ptr)
    );

    fcb_ptr_wrap #(.depth(depth)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_pop),
        .o_ptr (w_rd_ptr)
    );

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Full/valid flags are precomputed from the next count so ports come from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_not_full <= 1'b1;
            r_down_vld <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_not_full <= (w_count_nxt != CW'(depth));
            r_down_vld <= (w_count_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(depth); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[w_wr_ptr] <= up_data;
        end
    end

    assign down_vld  = r_down_vld;
    assign down_data = r_mem[w_rd_ptr];
    assign count     = r_count;

endmodule

// File: tb/tb_fcb_n_deep_parametrised.sv
// Six buffer configurations share one stimulus stream; each is checked against a queue model.
module tb_fcb_n_deep_parametrised;

    localparam int NDUT = 6;
    localparam int unsigned WS [NDUT] = '{8, 8, 8, 8, 16, 16};
    localparam int unsigned DS [NDUT] = '{2, 4, 4, 3, 5, 5};
    localparam int unsigned CS [NDUT] = '{0, 0, 1, 0, 0, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        up_vld;
    logic        down_rdy;
    logic [15:0] up_data;

    logic        o_dv  [NDUT];
    logic        o_ur  [NDUT];
    logic [15:0] o_dd  [NDUT];
    logic [7:0]  o_cnt [NDUT];

    int errors = 0;
    int checks = 0;

    logic [15:0] mq [NDUT][$];
    bit          zero_store [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned GW  = WS[g];
        localparam int unsigned GD  = DS[g];
        localparam int unsigned GCR = CS[g];
        localparam int unsigned GC  = $clog2(GD + 1);
        logic          dv;
        logic          ur;
        logic [GW-1:0] dd;
        logic [GC-1:0] cnt;

        fcb_n_deep_parametrised #(.w(GW), .depth(GD), .comb_rdy(GCR)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .up_vld    (up_vld),
            .up_rdy    (ur),
            .up_data   (up_data[GW-1:0]),
            .down_vld  (dv),
            .down_rdy  (down_rdy),
            .down_data (dd),
            .count     (cnt)
        );

        assign o_dv[g]  = dv;
        assign o_ur[g]  = ur;
        assign o_dd[g]  = 16'(dd);
        assign o_cnt[g] = 8'(cnt);
    end

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [15:0] mask(input int k);
        return (WS[k] == 16) ? 16'hFFFF : 16'h00FF;
    endfunction

    function automatic bit exp_rdy(input int k, input logic dr);
        return (mq[k].size() != int'(DS[k])) || ((CS[k] != 0) && dr);
    endfunction

    // One clock: check every DUT against its model, then advance the models.
    task automatic cycle();
        bit          pu [NDUT];
        bit          po [NDUT];
        logic        dr;
        logic [15:0] ud;
        #1;
        dr = down_rdy;
        ud = up_data;
        down_rdy = ~dr;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            if (CS[k] == 0) chk("rdy_indep", k, 32'(o_ur[k]), 32'(mq[k].size() != int'(DS[k])));
        end
        down_rdy = dr;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk("up_rdy", k, 32'(o_ur[k]), 32'(exp_rdy(k, dr)));
            chk("count", k, 32'(o_cnt[k]), 32'(mq[k].size()));
            chk("down_vld", k, 32'(o_dv[k]), 32'(mq[k].size() != 0));
            if (mq[k].size() != 0) chk("down_data", k, 32'(o_dd[k]), 32'(mq[k][0]));
            else if (zero_store[k]) chk("down_data_rst", k, 32'(o_dd[k]), 32'h0);
            pu[k] = !rst && up_vld && exp_rdy(k, dr);
            po[k] = !rst && dr && (mq[k].size() != 0);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            if (rst) begin
                mq[k].delete();
                zero_store[k] = 1'b1;
            end else begin
                if (po[k]) void'(mq[k].pop_front());
                if (pu[k]) begin
                    mq[k].push_back(ud & mask(k));
                    zero_store[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        up_vld = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int sent;
        int rcv;
        int n;

        rst = 1'b1;
        up_vld = 1'b0;
        down_rdy = 1'b0;
        up_data = '0;
        @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            mq[k].delete();
            zero_store[k] = 1'b1;
        end
        rst = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            chk("rst_count", k, 32'(o_cnt[k]), 32'h0);
            chk("rst_vld", k, 32'(o_dv[k]), 32'h0);
            chk("rst_data", k, 32'(o_dd[k]), 32'h0);
            chk("rst_up_rdy", k, 32'(o_ur[k]), 32'h1);
        end

        // Streaming through depth 2 at one transfer per cycle.
        down_rdy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            up_vld = 1'b1;
            up_data = 16'(i);
            cycle();
            chk("t1_data", 0, 32'(o_dd[0]), 32'(i));
            chk("t1_count", 0, 32'(o_cnt[0]), 32'h1);
            chk("t1_up_rdy", 0, 32'(o_ur[0]), 32'h1);
        end
        up_vld = 1'b0;
        cycle();
        chk("t1_empty", 0, 32'(o_cnt[0]), 32'h0);

        // Full behaviour in both modes at depth 4.
        do_reset();
        down_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            up_vld = 1'b1;
            up_data = 16'(16'hA0 + i);
            cycle();
        end
        chk("t2_full_cnt", 1, 32'(o_cnt[1]), 32'h4);
        chk("t2_full_cnt", 2, 32'(o_cnt[2]), 32'h4);
        chk("t2_full_rdy", 1, 32'(o_ur[1]), 32'h0);
        chk("t2_full_rdy", 2, 32'(o_ur[2]), 32'h0);
        down_rdy = 1'b1;
        up_data = 16'hA4;
        #1;
        chk("t2_pop_rdy", 1, 32'(o_ur[1]), 32'h0);
        chk("t2_pop_rdy", 2, 32'(o_ur[2]), 32'h1);
        chk("t2_head", 2, 32'(o_dd[2]), 32'hA0);
        cycle();
        chk("t2_cnt_after", 1, 32'(o_cnt[1]), 32'h3);
        chk("t2_cnt_after", 2, 32'(o_cnt[2]), 32'h4);
        up_vld = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk("t2_order", 2, 32'(o_dd[2]), 32'(16'hA0 + i));
            cycle();
        end
        chk("t2_drained", 1, 32'(o_cnt[1]), 32'h0);

        // Depth 3 wrap with random stalls on values 0..9.
        do_reset();
        sent = 0;
        rcv = 0;
        n = 0;
        while (rcv < 10 && n < 300) begin
            up_vld = (sent < 10) && ($urandom_range(0, 3) != 0);
            up_data = 16'(sent);
            down_rdy = ($urandom_range(0, 2) != 0);
            if (o_dv[3] && down_rdy) begin
                chk("t3_order", 3, 32'(o_dd[3]), 32'(rcv));
                rcv++;
            end
            if (up_vld && exp_rdy(3, down_rdy)) sent++;
            cycle();
            n++;
        end
        chk("t3_done", 3, 32'(rcv), 32'd10);

        // Output holds while stalled.
        do_reset();
        down_rdy = 1'b0;
        up_vld = 1'b1;
        up_data = 16'h5A;
        cycle();
        up_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t4_hold_data", 0, 32'(o_dd[0]), 32'h5A);
            chk("t4_hold_vld", 0, 32'(o_dv[0]), 32'h1);
        end

        // Reset mid-operation with a push in flight.
        do_reset();
        up_vld = 1'b1;
        up_data = 16'h11;
        cycle();
        up_data = 16'h22;
        cycle();
        chk("t5_pre_cnt", 0, 32'(o_cnt[0]), 32'h2);
        rst = 1'b1;
        up_data = 16'h33;
        cycle();
        rst = 1'b0;
        up_vld = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            chk("t5_count", k, 32'(o_cnt[k]), 32'h0);
            chk("t5_vld", k, 32'(o_dv[k]), 32'h0);
            chk("t5_data", k, 32'(o_dd[k]), 32'h0);
            chk("t5_up_rdy", k, 32'(o_ur[k]), 32'h1);
        end
        cycle();

        // Long random traffic with phase-varying pressure.
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            int pv;
            int pr;
            pv = 1 + (i / 1000) % 4;
            pr = 1 + ((i / 1000) + 2) % 4;
            up_vld = ($urandom_range(0, 4) < pv);
            down_rdy = ($urandom_range(0, 4) < pr);
            up_data = 16'($urandom);
            cycle();
        end
        up_vld = 1'b0;
        down_rdy = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        for (int k = 0; k < NDUT; k++) chk("t6_drained", k, 32'(o_cnt[k]), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
